// File: rtl/dead_or_alive_pkg.sv
// Shared photon definitions for the roulette stage: field widths, weight threshold,
// LFSR polynomial and the photon record carried down the pipeline.
package dead_or_alive_pkg;

    localparam int PH_BIT_WIDTH = 32;
    localparam int PH_LAYER_WIDTH = 3;
    localparam logic [PH_BIT_WIDTH-1:0] PH_WEIGHT_LIM = 32'h0010_0000;
    localparam logic [31:0] PH_LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] PH_LFSR_SEED = 32'hACE1_2345;

    typedef struct packed {
        logic [PH_BIT_WIDTH-1:0]   x;
        logic [PH_BIT_WIDTH-1:0]   y;
        logic [PH_BIT_WIDTH-1:0]   z;
        logic [PH_BIT_WIDTH-1:0]   ux;
        logic [PH_BIT_WIDTH-1:0]   uy;
        logic [PH_BIT_WIDTH-1:0]   uz;
        logic [PH_BIT_WIDTH-1:0]   sz;
        logic [PH_BIT_WIDTH-1:0]   sr;
        logic [PH_BIT_WIDTH-1:0]   sleftz;
        logic [PH_BIT_WIDTH-1:0]   sleftr;
        logic [PH_BIT_WIDTH-1:0]   weight;
        logic [PH_LAYER_WIDTH-1:0] layer;
        logic                      dead;
        logic                      hit;
    } photon_t;

    function automatic photon_t dead_photon();
        photon_t p;
        p = '0;
        p.dead = 1'b1;
        return p;
    endfunction

    // Galois right-shift step; the all-zero lock-up state recovers to the seed.
    function automatic logic [31:0] lfsr_next(input logic [31:0] q, input logic [31:0] seed);
        if (q == 32'h0)
            return seed;
        return q[0] ? ((q >> 1) ^ PH_LFSR_TAPS) : (q >> 1);
    endfunction

endpackage

// File: rtl/dead_or_alive_lfsr.sv
// Free-running 32-bit Galois LFSR supplying the roulette survival draw.
module roulette_lfsr
    import dead_or_alive_pkg::*;
#(
    parameter logic [31:0] SEED = PH_LFSR_SEED
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    output logic [31:0] q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            q <= SEED;
        else if (enable)
            q <= lfsr_next(q, SEED);
    end

endmodule

// File: rtl/dead_or_alive.sv
// Russian-roulette stage: low-weight live photons either survive with a boosted
// weight or are killed, in a fixed three-stage pipeline with saturating statistics.
module dead_or_alive
    import dead_or_alive_pkg::*;
#(
    parameter int                   BIT_WIDTH   = PH_BIT_WIDTH,
    parameter int                   LAYER_WIDTH = PH_LAYER_WIDTH,
    parameter logic [BIT_WIDTH-1:0] WEIGHT_LIM  = PH_WEIGHT_LIM,
    parameter int                   CHANCE_BITS = 4,
    parameter logic [31:0]          LFSR_SEED   = PH_LFSR_SEED
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   i_clear_counts,
    input  logic [BIT_WIDTH-1:0]   i_x,
    input  logic [BIT_WIDTH-1:0]   i_y,
    input  logic [BIT_WIDTH-1:0]   i_z,
    input  logic [BIT_WIDTH-1:0]   i_ux,
    input  logic [BIT_WIDTH-1:0]   i_uy,
    input  logic [BIT_WIDTH-1:0]   i_uz,
    input  logic [BIT_WIDTH-1:0]   i_sz,
    input  logic [BIT_WIDTH-1:0]   i_sr,
    input  logic [BIT_WIDTH-1:0]   i_sleftz,
    input  logic [BIT_WIDTH-1:0]   i_sleftr,
    input  logic [BIT_WIDTH-1:0]   i_weight,
    input  logic [LAYER_WIDTH-1:0] i_layer,
    input  logic                   i_dead,
    input  logic                   i_hit,
    output logic [BIT_WIDTH-1:0]   o_x,
    output logic [BIT_WIDTH-1:0]   o_y,
    output logic [BIT_WIDTH-1:0]   o_z,
    output logic [BIT_WIDTH-1:0]   o_ux,
    output logic [BIT_WIDTH-1:0]   o_uy,
    output logic [BIT_WIDTH-1:0]   o_uz,
    output logic [BIT_WIDTH-1:0]   o_sz,
    output logic [BIT_WIDTH-1:0]   o_sr,
    output logic [BIT_WIDTH-1:0]   o_sleftz,
    output logic [BIT_WIDTH-1:0]   o_sleftr,
    output logic [BIT_WIDTH-1:0]   o_weight,
    output logic [LAYER_WIDTH-1:0] o_layer,
    output logic                   o_dead,
    output logic                   o_hit,
    output logic [31:0]            o_roulette_count,
    output logic [31:0]            o_kill_count
);

    photon_t     in_ph;
    photon_t     ph_p0, ph_p1, ph_p2;
    logic        cand_p0, cand_p1;
    logic        survive_p1;
    logic [31:0] lfsr_q;
    logic        lfsr_unused;

    function automatic logic [PH_BIT_WIDTH-1:0] sat_boost(input logic [PH_BIT_WIDTH-1:0] w);
        if (w[PH_BIT_WIDTH-1 -: CHANCE_BITS] != '0)
            return '1;
        return w << CHANCE_BITS;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

    roulette_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .q      (lfsr_q)
    );

    // Only the low CHANCE_BITS of the LFSR decide survival.
    assign lfsr_unused = ^lfsr_q[31:CHANCE_BITS];

    always_comb begin
        in_ph        = '0;
        in_ph.x      = i_x;
        in_ph.y      = i_y;
        in_ph.z      = i_z;
        in_ph.ux     = i_ux;
        in_ph.uy     = i_uy;
        in_ph.uz     = i_uz;
        in_ph.sz     = i_sz;
        in_ph.sr     = i_sr;
        in_ph.sleftz = i_sleftz;
        in_ph.sleftr = i_sleftr;
        in_ph.weight = i_weight;
        in_ph.layer  = i_layer;
        in_ph.dead   = i_dead;
        in_ph.hit    = i_hit;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ph_p0      <= dead_photon();
            ph_p1      <= dead_photon();
            ph_p2      <= dead_photon();
            cand_p0    <= 1'b0;
            cand_p1    <= 1'b0;
            survive_p1 <= 1'b0;
        end else if (enable) begin
            // stage 1: capture and classify
            ph_p0      <= in_ph;
            cand_p0    <= !i_dead && !i_hit && (i_weight < WEIGHT_LIM);
            // stage 2: draw; a zero-weight candidate can never survive
            ph_p1      <= ph_p0;
            cand_p1    <= cand_p0;
            survive_p1 <= cand_p0 && (ph_p0.weight != '0) && (lfsr_q[CHANCE_BITS-1:0] == '0);
            // stage 3: apply verdict
            ph_p2      <= ph_p1;
            if (cand_p1) begin
                ph_p2.weight <= survive_p1 ? sat_boost(ph_p1.weight) : '0;
                ph_p2.dead   <= !survive_p1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_roulette_count <= 32'h0;
            o_kill_count     <= 32'h0;
        end else if (i_clear_counts) begin
            o_roulette_count <= 32'h0;
            o_kill_count     <= 32'h0;
        end else if (enable && cand_p1) begin
            o_roulette_count <= sat_inc(o_roulette_count);
            if (!survive_p1)
                o_kill_count <= sat_inc(o_kill_count);
        end
    end

    assign o_x      = ph_p2.x;
    assign o_y      = ph_p2.y;
    assign o_z      = ph_p2.z;
    assign o_ux     = ph_p2.ux;
    assign o_uy     = ph_p2.uy;
    assign o_uz     = ph_p2.uz;
    assign o_sz     = ph_p2.sz;
    assign o_sr     = ph_p2.sr;
    assign o_sleftz = ph_p2.sleftz;
    assign o_sleftr = ph_p2.sleftr;
    assign o_weight = ph_p2.weight;
    assign o_layer  = ph_p2.layer;
    assign o_dead   = ph_p2.dead;
    assign o_hit    = ph_p2.hit;

endmodule

// File: tb/tb_dead_or_alive.sv
// Randomized bench for dead_or_alive against a queue-based reference of the roulette rules.
module tb_dead_or_alive;

    localparam logic [31:0]  SEED     = 32'hACE1_2345;
    localparam logic [31:0]  TAPS     = 32'h8020_0003;
    localparam logic [31:0]  LIM      = 32'h0010_0000;
    localparam logic [356:0] DEAD_BUS = 357'd2;

    typedef struct packed {
        logic [356:0] bus;
        logic         cand;
        logic         kill;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic               i_clear_counts = 1'b0;
    logic [0:10][31:0]  in_f = '0;
    logic [2:0]         in_layer = 3'd0;
    logic               in_dead = 1'b0;
    logic               in_hit = 1'b0;

    logic [31:0] o_x, o_y, o_z, o_ux, o_uy, o_uz, o_sz, o_sr, o_sleftz, o_sleftr, o_weight;
    logic [2:0]  o_layer;
    logic        o_dead, o_hit;
    logic [31:0] o_roulette_count, o_kill_count;

    dead_or_alive dut (
        .clock (clock), .reset (reset), .enable (enable), .i_clear_counts (i_clear_counts),
        .i_x (in_f[0]), .i_y (in_f[1]), .i_z (in_f[2]), .i_ux (in_f[3]), .i_uy (in_f[4]),
        .i_uz (in_f[5]), .i_sz (in_f[6]), .i_sr (in_f[7]), .i_sleftz (in_f[8]),
        .i_sleftr (in_f[9]), .i_weight (in_f[10]), .i_layer (in_layer),
        .i_dead (in_dead), .i_hit (in_hit),
        .o_x (o_x), .o_y (o_y), .o_z (o_z), .o_ux (o_ux), .o_uy (o_uy), .o_uz (o_uz),
        .o_sz (o_sz), .o_sr (o_sr), .o_sleftz (o_sleftz), .o_sleftr (o_sleftr),
        .o_weight (o_weight), .o_layer (o_layer), .o_dead (o_dead), .o_hit (o_hit),
        .o_roulette_count (o_roulette_count), .o_kill_count (o_kill_count)
    );

    logic [356:0] obs;
    assign obs = {o_x, o_y, o_z, o_ux, o_uy, o_uz, o_sz, o_sr, o_sleftz, o_sleftr,
                  o_weight, o_layer, o_dead, o_hit};

    exp_t         q[$];
    logic [356:0] exp_bus;
    logic [31:0]  m_lfsr, exp_rc, exp_kc;
    int           n_cmp = 0;
    int           n_fail = 0;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        if (s == 32'h0) return SEED;
        return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    endfunction

    function automatic logic [31:0] boost(input logic [31:0] w);
        logic [63:0] p;
        p = {32'd0, w} * 64'd16;
        return (p > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
    endfunction

    task automatic model_reset();
        exp_t d;
        d.bus = DEAD_BUS; d.cand = 1'b0; d.kill = 1'b0;
        q.delete();
        q.push_back(d);
        q.push_back(d);
        m_lfsr = SEED; exp_rc = 0; exp_kc = 0; exp_bus = DEAD_BUS;
    endtask

    // One clock: the photon on the inputs gets its verdict from the LFSR value
    // the pipeline will hold when it reaches the draw stage.
    task automatic step(input bit en, input bit clr);
        exp_t e, f;
        logic [31:0] nxt, w;
        logic cand, surv, od;
        logic [0:10][31:0] of;
        enable = en; i_clear_counts = clr;
        nxt  = lfsr_next(m_lfsr);
        w    = in_f[10];
        cand = !in_dead && !in_hit && (w < LIM);
        surv = cand && (w != 0) && (nxt[3:0] == 4'h0);
        of = in_f; od = in_dead;
        if (cand) begin
            of[10] = surv ? boost(w) : 32'h0;
            od = !surv;
        end
        e.bus = {of, in_layer, od, in_hit}; e.cand = cand; e.kill = cand && !surv;
        @(posedge clock);
        if (en) begin
            q.push_back(e);
            m_lfsr = nxt;
            f = q.pop_front();
            exp_bus = f.bus;
            if (f.cand && exp_rc != 32'hFFFF_FFFF) exp_rc = exp_rc + 1;
            if (f.kill && exp_kc != 32'hFFFF_FFFF) exp_kc = exp_kc + 1;
        end
        if (clr) begin exp_rc = 0; exp_kc = 0; end
        #1;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < 10; i++) in_f[i] = $urandom;
        in_layer = 3'($urandom_range(0, 7));
        in_dead = 1'b0; in_hit = 1'b0;
    endtask

    task automatic filler();
        rand_fields();
        in_f[10] = LIM + ($urandom & 32'h0FFF_FFFF);
    endtask

    task automatic rand_photon();
        int r;
        rand_fields();
        r = $urandom_range(0, 99);
        if (r < 5)       in_f[10] = 32'h0;
        else if (r < 45) in_f[10] = $urandom_range(1, 32'h000F_FFFF);
        else             in_f[10] = $urandom;
        in_dead = ($urandom_range(0, 6) == 0);
        in_hit  = ($urandom_range(0, 6) == 0);
    endtask

    task automatic flush_and_clear();
        filler(); step(1, 0); step(1, 0);
        step(1, 1);
    endtask

    task automatic align(input logic [3:0] nib, output bit ok);
        logic [31:0] nx;
        ok = 1'b0;
        for (int k = 0; k < 500; k++) begin
            nx = lfsr_next(m_lfsr);
            if (nx[3:0] == nib) begin ok = 1'b1; return; end
            filler(); step(1, 0);
        end
    endtask

    task automatic test_reset(input string tag);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== DEAD_BUS) begin n_fail++; $display("FAIL %s_outputs got=%h want=%h", tag, obs, DEAD_BUS); end
        n_cmp++;
        if (o_roulette_count !== 32'h0 || o_kill_count !== 32'h0) begin
            n_fail++; $display("FAIL %s_counts got=%h/%h want=0/0", tag, o_roulette_count, o_kill_count);
        end
        n_cmp++;
        if (dut.lfsr_q !== SEED) begin n_fail++; $display("FAIL %s_lfsr got=%h want=%h", tag, dut.lfsr_q, SEED); end
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_pass_through();
        logic [356:0] want;
        flush_and_clear();
        rand_fields(); in_f[10] = 32'h0020_0000;
        want = {in_f, in_layer, 1'b0, 1'b0};
        step(1, 0);
        filler(); step(1, 0); step(1, 0);
        n_cmp++;
        if (obs !== want || obs !== exp_bus) begin n_fail++; $display("FAIL pass_through got=%h want=%h", obs, want); end
        n_cmp++;
        if (o_roulette_count !== 32'h0 || o_kill_count !== 32'h0) begin
            n_fail++; $display("FAIL pass_through_counts got=%h/%h want=0/0", o_roulette_count, o_kill_count);
        end
    endtask

    task automatic test_verdict(input string tag, input logic [3:0] nib, input logic [31:0] w,
                                input logic [31:0] want_w, input logic want_dead, input logic [31:0] want_kc);
        bit ok;
        logic [31:0] sx;
        flush_and_clear();
        align(nib, ok);
        n_cmp++;
        if (!ok) begin n_fail++; $display("FAIL %s_align got=none want=nibble %h", tag, nib); end
        rand_fields(); in_f[10] = w; sx = in_f[0];
        step(1, 0);
        filler(); step(1, 0); step(1, 0);
        n_cmp++;
        if (o_weight !== want_w || o_dead !== want_dead || o_x !== sx || obs !== exp_bus) begin
            n_fail++; $display("FAIL %s_out got=w%h d%b x%h want=w%h d%b x%h", tag, o_weight, o_dead, o_x, want_w, want_dead, sx);
        end
        n_cmp++;
        if (o_roulette_count !== 32'h1 || o_kill_count !== want_kc) begin
            n_fail++; $display("FAIL %s_counts got=%h/%h want=1/%h", tag, o_roulette_count, o_kill_count, want_kc);
        end
    endtask

    task automatic test_dead_hit();
        logic [356:0] want [2];
        flush_and_clear();
        for (int k = 0; k < 2; k++) begin
            rand_fields(); in_f[10] = 32'h1;
            in_dead = (k == 0); in_hit = (k == 1);
            want[k] = {in_f, in_layer, in_dead, in_hit};
            step(1, 0);
        end
        filler(); step(1, 0);
        n_cmp++;
        if (obs !== want[0]) begin n_fail++; $display("FAIL dead_pass got=%h want=%h", obs, want[0]); end
        step(1, 0);
        n_cmp++;
        if (obs !== want[1]) begin n_fail++; $display("FAIL hit_pass got=%h want=%h", obs, want[1]); end
        n_cmp++;
        if (o_roulette_count !== 32'h0 || o_kill_count !== 32'h0) begin
            n_fail++; $display("FAIL dead_hit_counts got=%h/%h want=0/0", o_roulette_count, o_kill_count);
        end
    endtask

    task automatic test_clear_priority();
        bit ok;
        flush_and_clear();
        align(4'h7, ok);
        rand_fields(); in_f[10] = 32'h0000_0800;
        step(1, 0);
        filler(); step(1, 0);
        step(1, 1);
        n_cmp++;
        if (o_roulette_count !== 32'h0 || o_kill_count !== 32'h0 || obs !== exp_bus) begin
            n_fail++; $display("FAIL clear_priority got=%h/%h want=0/0", o_roulette_count, o_kill_count);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            rand_photon();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
            n_cmp++;
            if (obs !== exp_bus || o_roulette_count !== exp_rc || o_kill_count !== exp_kc) begin
                n_fail++; $display("FAIL random_%0d got=%h c%h/%h want=%h c%h/%h", k, obs, o_roulette_count, o_kill_count, exp_bus, exp_rc, exp_kc);
            end
        end
    endtask

    task automatic test_statistics();
        int surv = 0;
        flush_and_clear();
        for (int k = 0; k < 10002; k++) begin
            if (k < 10000) begin rand_fields(); in_f[10] = 32'h0000_0100; end
            else filler();
            step(1, 0);
            if (o_weight == 32'h0000_1000 && o_dead == 1'b0) surv++;
            n_cmp++;
            if (obs !== exp_bus) begin n_fail++; $display("FAIL stats_%0d got=%h want=%h", k, obs, exp_bus); end
        end
        n_cmp++;
        if (surv < 525 || surv > 725) begin n_fail++; $display("FAIL stats_fraction got=%0d want=525..725", surv); end
        n_cmp++;
        if (o_roulette_count !== 32'd10000 || o_kill_count !== 32'(10000 - surv) || o_kill_count !== exp_kc) begin
            n_fail++; $display("FAIL stats_counts got=%0d/%0d want=10000/%0d", o_roulette_count, o_kill_count, 10000 - surv);
        end
    endtask

    task automatic test_enable_and_reset();
        logic [31:0] fx;
        for (int k = 0; k < 32; k++) begin
            rand_photon();
            step((k % 4 == 1 || k % 4 == 2) ? 1'b0 : 1'b1, 1'b0);
            n_cmp++;
            if (obs !== exp_bus || o_roulette_count !== exp_rc || o_kill_count !== exp_kc || dut.lfsr_q !== m_lfsr) begin
                n_fail++; $display("FAIL enable_%0d got=%h l%h want=%h l%h", k, obs, dut.lfsr_q, exp_bus, m_lfsr);
            end
        end
        test_reset("reset_mid");
        for (int k = 0; k < 3; k++) begin
            rand_photon();
            if (k == 0) fx = in_f[0];
            step(1, 0);
            n_cmp++;
            if ((k < 2 && obs !== DEAD_BUS) || (k == 2 && o_x !== fx) || obs !== exp_bus) begin
                n_fail++; $display("FAIL after_reset_%0d got=%h want=%h", k, obs, exp_bus);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset("reset");
        test_pass_through();
        test_verdict("survivor", 4'h0, 32'h0000_1000, 32'h0001_0000, 1'b0, 32'h0);
        test_verdict("killed", 4'h7, 32'h0000_1000, 32'h0, 1'b1, 32'h1);
        test_verdict("zero_weight", 4'h0, 32'h0, 32'h0, 1'b1, 32'h1);
        test_dead_hit();
        test_clear_priority();
        test_random();
        test_statistics();
        test_enable_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dead_or_alive.md
DEAD_OR_ALIVE -- requirements
Module: dead_or_alive

Interface
REQ-001 Parameter BIT_WIDTH, default 32, width of every photon data field.
REQ-002 Parameter LAYER_WIDTH, default 3, width of layer index.
REQ-003 Parameter WEIGHT_LIM, default 32'h0010_0000, unsigned weight threshold below which roulette applies.
REQ-004 Parameter CHANCE_BITS, default 4, survival probability 1/2^CHANCE_BITS and weight boost factor 2^CHANCE_BITS.
REQ-005 Parameter LFSR_SEED, default 32'hACE1_2345, nonzero LFSR reset value.
REQ-006 clock  input  1  single clock; all state on rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 enable  input  1  pipeline advance; low = every register and LFSR hold.
REQ-009 i_clear_counts  input  1  synchronous clear of both statistics counters.
REQ-010 i_x, i_y, i_z, i_ux, i_uy, i_uz, i_sz, i_sr, i_sleftz, i_sleftr, i_weight  input  BIT_WIDTH each  photon state from the absorber stage.
REQ-011 i_layer  input  LAYER_WIDTH  current layer; i_dead, i_hit  input  1 each  status flags.
REQ-012 o_x .. o_sleftr, o_weight  output  BIT_WIDTH each; o_layer  output  LAYER_WIDTH; o_dead, o_hit  output  1 each  photon to the scatterer/next loop.
REQ-013 o_roulette_count, o_kill_count  output  32 each  saturating statistics.

Function
REQ-014 Latency SHALL be exactly 3 enabled cycles, one photon accepted and one emitted per enabled cycle, no bubbles.
REQ-015 Stage 1 SHALL register all fields and flag candidate = !i_dead & !i_hit & (i_weight < WEIGHT_LIM).
REQ-016 Stage 2 SHALL sample the current LFSR value for candidates; survive = (lfsr[CHANCE_BITS-1:0] == 0).
REQ-017 Stage 3 survivor: o_weight = i_weight << CHANCE_BITS, saturating to all-ones on overflow, o_dead=0.
REQ-018 Stage 3 non-survivor: o_weight=0, o_dead=1.
REQ-019 Candidate with weight exactly 0 SHALL be killed without consulting the LFSR.
REQ-020 Non-candidates (dead, hit, or weight >= WEIGHT_LIM) SHALL pass with all fields unchanged.
REQ-021 Fields other than weight/dead SHALL pass unchanged for every photon.
REQ-022 LFSR: 32-bit Galois, taps 32'h8020_0003, advances once per enabled cycle regardless of candidates.
REQ-023 LFSR reaching zero SHALL reload LFSR_SEED next enabled cycle.
REQ-024 o_roulette_count SHALL increment per candidate reaching stage 3; o_kill_count per candidate killed; both in same cycle when applicable.
REQ-025 Counters SHALL saturate at 32'hFFFF_FFFF; i_clear_counts has priority over increment in the same cycle.
REQ-026 enable low mid-pipeline SHALL freeze data, flags, LFSR and counters; resume loses or duplicates nothing.

Reset
REQ-027 On reset low all pipeline registers SHALL immediately go to zero except dead=1 at every stage (including o_dead).
REQ-028 On reset LFSR = LFSR_SEED; both counters = 0.
REQ-029 Reset mid-operation SHALL discard in-flight photons; first valid output appears 3 enabled cycles after deassertion.

Structure
REQ-030 BIT_WIDTH, LAYER_WIDTH, WEIGHT_LIM, LFSR polynomial and the photon field record type SHALL live in the shared photon package.
REQ-031 The LFSR SHALL be a sub-module roulette_lfsr (clock, reset, enable, q).
REQ-032 No memories; all state in flip-flops.

Verification
REQ-033 Weight 32'h0020_0000, alive, not hit -> emerges after 3 cycles unchanged, counters unchanged.
REQ-034 Weight 32'h0000_1000, LFSR forced low nibble 0 -> o_weight 32'h0001_0000, o_dead=0, roulette_count=1, kill_count=0.
REQ-035 Weight 32'h0000_1000, LFSR low nibble 4'h7 -> o_weight 0, o_dead=1, both counters=1.
REQ-036 i_dead=1 or i_hit=1 with weight 1 -> all fields unchanged after 3 cycles, no count.
REQ-037 10,000 candidates weight 32'h0000_0100 -> survivor fraction 1/16 within ±1%, survivors weight 32'h0000_1000.
REQ-038 enable toggled 1-0-0-1 with stream, plus reset pulse mid-stream -> order preserved while enabled; after reset o_dead=1, outputs zero, LFSR=LFSR_SEED.
